// File: rtl/cmp_chunk_seq.sv
// Chunk-serial magnitude compare sequencer: folds MSB-first 2-bit comparator flag
// triples into one registered full-width verdict (b>a, a>b, a==b) plus a format error flag.
module cmp_chunk_seq #(
    parameter int NCHUNK = 4,
    parameter int CW     = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          in_valid,
    input  logic          b_gt,
    input  logic          a_gt,
    input  logic          eq,
    output logic          in_ready,
    output logic          busy,
    output logic          done,
    output logic          res_x,
    output logic          res_y,
    output logic          res_z,
    output logic          err,
    output logic [CW-1:0] chunk_cnt
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [CW-1:0] LAST_CNT = CW'(NCHUNK - 1);

    function automatic logic is_one_hot(input logic [2:0] f);
        return (f == 3'b100) || (f == 3'b010) || (f == 3'b001);
    endfunction

    logic [1:0]    state_r;
    logic [1:0]    state_s;
    logic [CW-1:0] cnt_r;
    logic          decided_r;
    logic          res_x_r;
    logic          res_y_r;
    logic          res_z_r;
    logic          err_r;
    logic          busy_r;
    logic          done_r;

    logic [2:0] flags_s;
    logic       one_hot_s;
    logic       accept_s;
    logic       last_s;
    logic       clear_s;
    logic       take_x_s;
    logic       take_y_s;

    // Chunk acceptance decode; malformed triples never decide the verdict
    always_comb begin
        flags_s   = {b_gt, a_gt, eq};
        one_hot_s = is_one_hot(flags_s);
        accept_s  = (state_r == ST_RUN) && in_valid;
        last_s    = accept_s && (cnt_r == LAST_CNT);
        clear_s   = start && ((state_r == ST_IDLE) || (state_r == ST_DONE));
        take_x_s  = accept_s && !decided_r && one_hot_s && b_gt;
        take_y_s  = accept_s && !decided_r && one_hot_s && a_gt;
    end

    // Next-state selection
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) state_s = ST_RUN;
                else       state_s = ST_IDLE;
            end
            ST_RUN: begin
                if (last_s) state_s = ST_DONE;
                else        state_s = ST_RUN;
            end
            ST_DONE: begin
                if (start) state_s = ST_RUN;
                else       state_s = ST_IDLE;
            end
            default: state_s = ST_IDLE;
        endcase
    end

    // State, status outputs and verdict registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= ST_IDLE;
            cnt_r     <= {CW{1'b0}};
            decided_r <= 1'b0;
            res_x_r   <= 1'b0;
            res_y_r   <= 1'b0;
            res_z_r   <= 1'b0;
            err_r     <= 1'b0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
        end else begin
            state_r <= state_s;
            busy_r  <= (state_s == ST_RUN);
            done_r  <= (state_s == ST_DONE);
            if (clear_s) begin
                cnt_r     <= {CW{1'b0}};
                decided_r <= 1'b0;
                res_x_r   <= 1'b0;
                res_y_r   <= 1'b0;
                res_z_r   <= 1'b0;
                err_r     <= 1'b0;
            end else if (accept_s) begin
                cnt_r <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
                if (!one_hot_s) err_r <= 1'b1;
                else            err_r <= err_r;
                if (take_x_s || take_y_s) decided_r <= 1'b1;
                else                      decided_r <= decided_r;
                if (take_x_s) res_x_r <= 1'b1;
                else          res_x_r <= res_x_r;
                if (take_y_s) res_y_r <= 1'b1;
                else          res_y_r <= res_y_r;
                // Equal only if neither earlier chunks nor this final one decided
                if (last_s && !decided_r && !take_x_s && !take_y_s) res_z_r <= 1'b1;
                else                                                res_z_r <= res_z_r;
            end else begin
                cnt_r     <= cnt_r;
                decided_r <= decided_r;
                res_x_r   <= res_x_r;
                res_y_r   <= res_y_r;
                res_z_r   <= res_z_r;
                err_r     <= err_r;
            end
        end
    end

    assign in_ready  = busy_r;
    assign busy      = busy_r;
    assign done      = done_r;
    assign res_x     = res_x_r;
    assign res_y     = res_y_r;
    assign res_z     = res_z_r;
    assign err       = err_r;
    assign chunk_cnt = cnt_r;

endmodule

// File: tb/tb_cmp_chunk_seq.sv
// Directed bench for cmp_chunk_seq: a phase/sequence model scored every cycle
// plus hand-computed literal expectations per scenario.
module tb_cmp_chunk_seq;

    localparam int N  = 4;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst, start, in_valid, b_gt, a_gt, eq;
    logic          in_ready, busy, done, res_x, res_y, res_z, err;
    logic [CW-1:0] chunk_cnt;

    int n_checks = 0;
    int n_pass   = 0;
    bit cmp_en   = 1'b0;

    cmp_chunk_seq #(.NCHUNK(N), .CW(CW)) dut (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid),
        .b_gt(b_gt), .a_gt(a_gt), .eq(eq),
        .in_ready(in_ready), .busy(busy), .done(done),
        .res_x(res_x), .res_y(res_y), .res_z(res_z),
        .err(err), .chunk_cnt(chunk_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Model: phase 0 idle, 1 collecting, 2 finished; verdict = first well-formed unequal chunk
    int         m_phase;
    int         m_cnt;
    logic [2:0] m_seq [N];
    logic [2:0] m_res;
    logic       m_err;

    function automatic logic [2:0] verdict(input logic [2:0] s [N], input logic [2:0] last);
        for (int i = 0; i < N - 1; i++) begin
            if (s[i] == 3'b100 || s[i] == 3'b010) return s[i];
        end
        if (last == 3'b100 || last == 3'b010) return last;
        return 3'b001;
    endfunction

    function automatic logic well_formed(input logic [2:0] f);
        return $countones(f) == 1;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_phase <= 0; m_cnt <= 0; m_res <= 3'b000; m_err <= 1'b0;
        end else if (m_phase != 1) begin
            if (start) begin
                m_phase <= 1; m_cnt <= 0; m_res <= 3'b000; m_err <= 1'b0;
            end else begin
                m_phase <= 0;
            end
        end else if (in_valid) begin
            m_seq[m_cnt] <= {b_gt, a_gt, eq};
            m_cnt        <= m_cnt + 1;
            if (!well_formed({b_gt, a_gt, eq})) m_err <= 1'b1;
            if (m_cnt + 1 == N) begin
                m_phase <= 2;
                m_res   <= verdict(m_seq, well_formed({b_gt, a_gt, eq}) ? {b_gt, a_gt, eq} : 3'b001);
            end
        end
    end

    // Per-cycle scoreboard; mid-compare results are only pinned once a verdict is final
    always @(negedge clk) begin
        if (cmp_en) begin
            check("m_busy",     {31'd0, busy},       {31'd0, m_phase == 1});
            check("m_in_ready", {31'd0, in_ready},   {31'd0, m_phase == 1});
            check("m_done",     {31'd0, done},       {31'd0, m_phase == 2});
            check("m_cnt",      {28'd0, chunk_cnt},  m_cnt);
            check("m_err",      {31'd0, err},        {31'd0, m_err});
            if (m_phase != 1)
                check("m_res", {29'd0, res_x, res_y, res_z}, {29'd0, m_res});
        end
    end

    task automatic cyc(input logic s, input logic v, input logic [2:0] f);
        start = s; in_valid = v; {b_gt, a_gt, eq} = f;
        @(negedge clk);
    endtask

    task automatic run4(input logic [2:0] c0, input logic [2:0] c1,
                        input logic [2:0] c2, input logic [2:0] c3);
        cyc(1'b1, 1'b0, 3'b000);
        cyc(1'b0, 1'b1, c0);
        cyc(1'b0, 1'b1, c1);
        cyc(1'b0, 1'b1, c2);
        check("pre_done", {31'd0, done}, 32'd0);
        cyc(1'b0, 1'b1, c3);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; in_valid = 1'b0; {b_gt, a_gt, eq} = 3'b000;
        @(negedge clk);
        @(negedge clk);
        cmp_en = 1'b1;
        check("rst_cnt",  {28'd0, chunk_cnt}, 32'd0);
        check("rst_res",  {29'd0, res_x, res_y, res_z}, 32'd0);
        check("rst_busy", {30'd0, busy, done}, 32'd0);
        rst = 1'b0;

        // Reset mid-compare after two chunks
        cyc(1'b1, 1'b0, 3'b000);
        cyc(1'b0, 1'b1, 3'b100);
        cyc(1'b0, 1'b1, 3'b001);
        rst = 1'b1;
        cyc(1'b0, 1'b1, 3'b001);
        rst = 1'b0;
        check("mid_rst_cnt",  {28'd0, chunk_cnt}, 32'd0);
        check("mid_rst_res",  {29'd0, res_x, res_y, res_z}, 32'd0);
        check("mid_rst_done", {30'd0, busy, done}, 32'd0);
        run4(3'b001, 3'b001, 3'b001, 3'b001);
        check("after_rst_res", {29'd0, res_x, res_y, res_z}, 32'b001);
        cyc(1'b0, 1'b0, 3'b000);

        // All equal: done in cycle 5 after start
        run4(3'b001, 3'b001, 3'b001, 3'b001);
        check("eq_done", {31'd0, done}, 32'd1);
        check("eq_res",  {29'd0, res_x, res_y, res_z}, 32'b001);
        check("eq_err",  {31'd0, err}, 32'd0);
        check("eq_cnt",  {28'd0, chunk_cnt}, 32'd4);
        cyc(1'b0, 1'b1, 3'b100);
        check("idle_hold", {29'd0, res_x, res_y, res_z}, 32'b001);

        // MSB decides, later b>a ignored
        run4(3'b010, 3'b100, 3'b100, 3'b100);
        check("msb_res", {29'd0, res_x, res_y, res_z}, 32'b010);
        cyc(1'b0, 1'b0, 3'b000);

        // Stalls, decision on last chunk
        cyc(1'b1, 1'b0, 3'b000);
        cyc(1'b0, 1'b1, 3'b001);
        cyc(1'b0, 1'b1, 3'b001);
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 3'b100);
        check("stall_cnt", {28'd0, chunk_cnt}, 32'd2);
        cyc(1'b0, 1'b1, 3'b001);
        check("stall_busy", {31'd0, busy}, 32'd1);
        cyc(1'b0, 1'b1, 3'b100);
        check("late_done", {31'd0, done}, 32'd1);
        check("late_res",  {29'd0, res_x, res_y, res_z}, 32'b100);
        check("late_cnt",  {28'd0, chunk_cnt}, 32'd4);
        cyc(1'b0, 1'b0, 3'b000);

        // Malformed flags; DONE entered, then start held for back-to-back
        run4(3'b001, 3'b011, 3'b001, 3'b001);
        check("bad_err", {31'd0, err}, 32'd1);
        check("bad_res", {29'd0, res_x, res_y, res_z}, 32'b001);
        cyc(1'b1, 1'b0, 3'b000);
        check("b2b_busy", {30'd0, busy, done}, 32'b10);
        check("b2b_err",  {31'd0, err}, 32'd0);
        cyc(1'b1, 1'b1, 3'b001);
        check("run_start_cnt", {28'd0, chunk_cnt}, 32'd1);
        cyc(1'b1, 1'b1, 3'b111);
        cyc(1'b0, 1'b1, 3'b001);
        cyc(1'b0, 1'b1, 3'b010);
        check("b2b_res", {29'd0, res_x, res_y, res_z}, 32'b010);
        check("b2b_bad_err", {31'd0, err}, 32'd1);
        cyc(1'b0, 1'b0, 3'b000);
        check("to_idle", {30'd0, busy, done}, 32'd0);
        cyc(1'b0, 1'b0, 3'b000);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
